// File: rtl/config_pkg.sv
// Core configuration record: the datapath widths shared by the execute-stage blocks.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned TRANS_ID_BITS;
    int unsigned NUM_THREADS_LOG;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32, TRANS_ID_BITS: 3, NUM_THREADS_LOG: 1};

endpackage

// File: rtl/mult_wb_buffer_pkg.sv
// Shared types for the multiplier writeback buffer.
// The entry layout follows the core configuration widths.
package mult_wb_buffer_pkg;

  localparam int unsigned MWB_XLEN     = config_pkg::cva6_cfg_empty.XLEN;
  localparam int unsigned MWB_TID_BITS = config_pkg::cva6_cfg_empty.TRANS_ID_BITS;
  localparam int unsigned MWB_THR_BITS = config_pkg::cva6_cfg_empty.NUM_THREADS_LOG;

  typedef struct packed {
    logic [MWB_XLEN-1:0]     result;
    logic [MWB_TID_BITS-1:0] trans_id;
    logic [MWB_THR_BITS-1:0] thread_id;
  } mult_wb_entry_t;

endpackage

// File: rtl/mult_wb_fifo.sv
// Generic circular FIFO: storage array, read/write pointers and occupancy count.
// Push while full is honoured only together with a pop.
module mult_wb_fifo
  import mult_wb_buffer_pkg::*;
#(
  parameter type         entry_t = mult_wb_entry_t,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  entry_t       data_i,
  output entry_t       data_o,
  output logic [PTR_W:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage is cleared on reset so the head data reads as zero out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (PTR_W+1)'(1);
      else if (!push_ok && pop_ok) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/mult_wb_buffer.sv
// Receive-side buffer for the non-stallable multiplier: captures every result and
// drains it to writeback. Optional same-cycle bypass when empty: MULT_WB_BYPASS_EN.
module mult_wb_buffer
  import mult_wb_buffer_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               issue_valid_i,
  output logic                               mult_ready_o,
  input  logic                               mult_valid_i,
  input  logic [CVA6Cfg.XLEN-1:0]            mult_result_i,
  input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]   mult_trans_id_i,
  input  logic [CVA6Cfg.NUM_THREADS_LOG-1:0] thread_id_i,
  output logic                               wb_valid_o,
  input  logic                               wb_ready_i,
  output logic [CVA6Cfg.XLEN-1:0]            wb_result_o,
  output logic [CVA6Cfg.TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [CVA6Cfg.NUM_THREADS_LOG-1:0] wb_thread_id_o,
  output logic                               overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W+1)'(DEPTH);

  mult_wb_entry_t   entry_in, head, wb_entry;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;
  logic             inflight_q, overflow_q, ovf_event;

  always_comb begin
    entry_in           = '0;
    entry_in.result    = mult_result_i;
    entry_in.trans_id  = mult_trans_id_i;
    entry_in.thread_id = thread_id_i;
  end

  // Every issued op holds a credit until its result lands, so a slot is always free for it.
  assign mult_ready_o = !rst_i &&
                        (({1'b0, count} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_EXT);

  assign pop = !empty && wb_ready_i;

`ifdef MULT_WB_BYPASS_EN
  logic bypass_v;
  assign bypass_v   = empty && mult_valid_i && !flush_i;
  assign wb_valid_o = !empty || bypass_v;
  assign wb_entry   = bypass_v ? entry_in : head;
  assign push       = mult_valid_i && !flush_i && !(bypass_v && wb_ready_i);
`else
  assign wb_valid_o = !empty;
  assign wb_entry   = head;
  assign push       = mult_valid_i && !flush_i;
`endif

  assign ovf_event = mult_valid_i && !flush_i && full && !pop;

  assign wb_result_o    = wb_entry.result;
  assign wb_trans_id_o  = wb_entry.trans_id;
  assign wb_thread_id_o = wb_entry.thread_id;
  assign overflow_o     = overflow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      inflight_q <= flush_i ? 1'b0 : (issue_valid_i && mult_ready_o);
      if (ovf_event) overflow_q <= 1'b1;
    end
  end

  mult_wb_fifo #(
    .entry_t (mult_wb_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (entry_in),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_mult_wb_buffer.sv
// Directed bench for mult_wb_buffer: drain order, backpressure, overflow, flush, reset.
module tb_mult_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        issue_valid_i;
  logic        mult_ready_o;
  logic        mult_valid_i;
  logic [31:0] mult_result_i;
  logic [2:0]  mult_trans_id_i;
  logic [0:0]  thread_id_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_result_o;
  logic [2:0]  wb_trans_id_o;
  logic [0:0]  wb_thread_id_o;
  logic        overflow_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] b_res [3] = '{32'h11, 32'h22, 32'h33};
  logic [2:0]  b_tid [3] = '{3'd1, 3'd2, 3'd3};
  logic [0:0]  b_thr [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] d_res [4] = '{32'h41, 32'h42, 32'h43, 32'hAB};
  logic [2:0]  d_tid [4] = '{3'd1, 3'd2, 3'd3, 3'd5};

  mult_wb_buffer #(.DEPTH(4)) u_dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .issue_valid_i   (issue_valid_i),
    .mult_ready_o    (mult_ready_o),
    .mult_valid_i    (mult_valid_i),
    .mult_result_i   (mult_result_i),
    .mult_trans_id_i (mult_trans_id_i),
    .thread_id_i     (thread_id_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_result_o     (wb_result_o),
    .wb_trans_id_o   (wb_trans_id_o),
    .wb_thread_id_o  (wb_thread_id_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_res(input logic [31:0] r, input logic [2:0] t, input logic [0:0] th);
    mult_valid_i    = 1'b1;
    mult_result_i   = r;
    mult_trans_id_i = t;
    thread_id_i     = th;
  endtask

  initial begin
    int accepted, res_idx;
    logic fire, prev_fire;

    rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; mult_valid_i = 1'b0;
    mult_result_i = '0; mult_trans_id_i = '0; thread_id_i = '0; wb_ready_i = 1'b0;
    tick(); tick();
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_wb_result", wb_result_o, 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_mult_ready", 32'(mult_ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", 32'(mult_ready_o), 32'd1);

    // basic push/drain
    issue_valid_i = 1'b1; wb_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_res(b_res[i], b_tid[i], b_thr[i]);
      issue_valid_i = (i < 2);
      #1;
`ifdef MULT_WB_BYPASS_EN
      check("basic_valid", 32'(wb_valid_o), 32'd1);
      check("basic_result", wb_result_o, b_res[i]);
      check("basic_tid", 32'(wb_trans_id_o), 32'(b_tid[i]));
      check("basic_thr", 32'(wb_thread_id_o), 32'(b_thr[i]));
`else
      if (i == 0) begin
        check("basic_lat_valid", 32'(wb_valid_o), 32'd0);
      end else begin
        check("basic_valid", 32'(wb_valid_o), 32'd1);
        check("basic_result", wb_result_o, b_res[i-1]);
        check("basic_tid", 32'(wb_trans_id_o), 32'(b_tid[i-1]));
        check("basic_thr", 32'(wb_thread_id_o), 32'(b_thr[i-1]));
      end
`endif
      tick();
    end
    mult_valid_i = 1'b0; issue_valid_i = 1'b0;
    #1;
`ifndef MULT_WB_BYPASS_EN
    check("basic_last_result", wb_result_o, b_res[2]);
    check("basic_last_tid", 32'(wb_trans_id_o), 32'(b_tid[2]));
`endif
    tick();
    check("basic_empty", 32'(wb_valid_o), 32'd0);
    check("basic_count", 32'(u_dut.u_fifo.count_q), 32'd0);

    // backpressure: issue until the credit runs out
    wb_ready_i = 1'b0; prev_fire = 1'b0; accepted = 0; res_idx = 0;
    for (int c = 0; c < 8; c++) begin
      mult_valid_i = 1'b0;
      if (prev_fire) begin
        drive_res(32'h40 + 32'(res_idx), 3'(res_idx), 1'(res_idx));
        res_idx++;
      end
      issue_valid_i = 1'b1;
      #1;
      fire = mult_ready_o;
      if (fire) accepted++;
      tick();
      prev_fire = fire;
    end
    issue_valid_i = 1'b0; mult_valid_i = 1'b0;
    #1;
    check("stall_accepted", 32'(accepted), 32'd4);
    check("stall_count", 32'(u_dut.u_fifo.count_q), 32'd4);
    check("stall_ready", 32'(mult_ready_o), 32'd0);
    check("stall_overflow", 32'(overflow_o), 32'd0);
    check("stall_head", wb_result_o, 32'h40);

    // forced overflow at full with no pop
    drive_res(32'hEE, 3'd7, 1'b1);
    tick();
    mult_valid_i = 1'b0;
    #1;
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_count", 32'(u_dut.u_fifo.count_q), 32'd4);
    check("ovf_head", wb_result_o, 32'h40);

    // simultaneous push and pop while full
    drive_res(32'hAB, 3'd5, 1'b1);
    wb_ready_i = 1'b1;
    #1;
    check("pp_head_before", wb_result_o, 32'h40);
    tick();
    mult_valid_i = 1'b0; wb_ready_i = 1'b0;
    #1;
    check("pp_count", 32'(u_dut.u_fifo.count_q), 32'd4);
    check("pp_head_after", wb_result_o, 32'h41);
    check("ovf_held", 32'(overflow_o), 32'd1);

    wb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_valid", 32'(wb_valid_o), 32'd1);
      check("drain_result", wb_result_o, d_res[i]);
      check("drain_tid", 32'(wb_trans_id_o), 32'(d_tid[i]));
      tick();
    end
    check("drain_empty", 32'(wb_valid_o), 32'd0);

    // flush with 3 buffered and 1 in flight
    wb_ready_i = 1'b0; issue_valid_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_res(32'h60 + 32'(i), 3'(i), 1'b0);
      tick();
    end
    issue_valid_i = 1'b0; flush_i = 1'b1;
    drive_res(32'h63, 3'd3, 1'b0);
    #1;
    check("pre_flush_count", 32'(u_dut.u_fifo.count_q), 32'd3);
    check("pre_flush_ready", 32'(mult_ready_o), 32'd0);
    tick();
    flush_i = 1'b0; mult_valid_i = 1'b0;
    #1;
    check("flush_valid", 32'(wb_valid_o), 32'd0);
    check("flush_ready", 32'(mult_ready_o), 32'd1);
    check("flush_count", 32'(u_dut.u_fifo.count_q), 32'd0);
    check("flush_ovf_kept", 32'(overflow_o), 32'd1);
    tick();
    check("flush_discard", 32'(wb_valid_o), 32'd0);

    // reset mid-drain with 2 buffered
    issue_valid_i = 1'b1;
    tick();
    drive_res(32'h71, 3'd1, 1'b1);
    tick();
    drive_res(32'h72, 3'd2, 1'b0);
    issue_valid_i = 1'b0;
    tick();
    mult_valid_i = 1'b0;
    #1;
    check("rmd_count", 32'(u_dut.u_fifo.count_q), 32'd2);
    check("rmd_head", wb_result_o, 32'h71);
    rst_i = 1'b1; wb_ready_i = 1'b1;
    #1;
    check("rmd_ready_in_rst", 32'(mult_ready_o), 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    check("rmd_valid", 32'(wb_valid_o), 32'd0);
    check("rmd_result", wb_result_o, 32'd0);
    check("rmd_tid", 32'(wb_trans_id_o), 32'd0);
    check("rmd_thr", 32'(wb_thread_id_o), 32'd0);
    check("rmd_overflow", 32'(overflow_o), 32'd0);
    check("rmd_ready", 32'(mult_ready_o), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rmd_no_wb", 32'(wb_valid_o), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
